// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - shared state encoding, widths and helpers for the APB master arbiter
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int STRB_W          = 4;
    localparam int PROT_W          = 3;
    localparam int IDX_W           = 2;
    localparam int TMO_W           = 8;
    localparam int DEFAULT_TIMEOUT = 255;

    // Requester index reached by stepping off+1 places past last, modulo n.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] last,
                                                  input int off, input int n);
        int c;
        c = int'(last) + 1 + off;
        if (c >= n) begin
            c = c - n;
        end
        return IDX_W'(c);
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester-side transaction ports and APB master bus
interface apb_master_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]        REQ_VALID;
    logic [ADDR_W*NUM_REQ-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]        REQ_WRITE;
    logic [DATA_W*NUM_REQ-1:0] REQ_WDATA;
    logic [STRB_W*NUM_REQ-1:0] REQ_STRB;
    logic [PROT_W*NUM_REQ-1:0] REQ_PROT;
    logic [NUM_REQ-1:0]        REQ_DONE;
    logic [DATA_W-1:0]         REQ_RDATA;
    logic                      REQ_ERR;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic [STRB_W-1:0]         PSTRB;
    logic [PROT_W-1:0]         PPROT;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB, REQ_PROT,
        input  PRDATA, PREADY, PSLVERR,
        output REQ_DONE, REQ_RDATA, REQ_ERR,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, REQ_WRITE, REQ_WDATA, REQ_STRB, REQ_PROT,
        output PRDATA, PREADY, PSLVERR,
        input  REQ_DONE, REQ_RDATA, REQ_ERR,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

endinterface

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational round-robin picker starting one past the last grant
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);
    logic [IDX_W:0]       shift_amt;
    logic [NUM_REQ-1:0]   rot;

    // Rotate so bit 0 is the requester right after the last grant; lowest set bit wins.
    always_comb begin
        shift_amt = {1'b0, last_i} + (IDX_W+1)'(1);
        rot       = NUM_REQ'({req_i, req_i} >> shift_amt);
        grant_o   = '0;
        any_o     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any_o   = 1'b1;
                grant_o = rr_index(last_i, k, NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin shared APB master with access-timeout watchdog
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb_master_arbiter_if.master bus
);
    localparam bit         TMO_EN  = (TIMEOUT != 0);
    localparam logic [8:0] TMO_VAL = 9'(TIMEOUT);

    apb_state_e          state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [PROT_W-1:0]   pprot_q;
    logic [NUM_REQ-1:0]  done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    win_q;
    logic [TMO_W-1:0]    cnt_q;
    logic [TMO_W-1:0]    cnt_d;
    logic                timeout_hit;

    logic [NUM_REQ-1:0]  eligible;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_write;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_strb;
    logic [PROT_W-1:0]   sel_prot;

    // A requester is masked in its own DONE cycle so it cannot be regranted on a stale request.
    assign eligible = bus.REQ_VALID & ~done_q;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (eligible),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr  = bus.REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_write = bus.REQ_WRITE[i];
                sel_wdata = bus.REQ_WDATA[i*DATA_W +: DATA_W];
                sel_strb  = bus.REQ_STRB[i*STRB_W +: STRB_W];
                sel_prot  = bus.REQ_PROT[i*PROT_W +: PROT_W];
            end
        end
    end

    assign cnt_d       = cnt_q + TMO_W'(1);
    assign timeout_hit = TMO_EN && (({1'b0, cnt_q} + 9'd1) == TMO_VAL);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            win_q     <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        win_q    <= pick_idx;
                        paddr_q  <= sel_addr;
                        pwrite_q <= sel_write;
                        pwdata_q <= sel_wdata;
                        pstrb_q  <= sel_write ? sel_strb : '0;
                        pprot_q  <= sel_prot;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // PREADY takes priority over an expiring watchdog in the same cycle.
                    if (bus.PREADY || timeout_hit) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done_q    <= NUM_REQ'(1) << win_q;
                        last_q    <= win_q;
                        state_q   <= ST_IDLE;
                        if (bus.PREADY) begin
                            rdata_q <= pwrite_q ? '0 : bus.PRDATA;
                            err_q   <= bus.PSLVERR;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PPROT     = pprot_q;
    assign bus.REQ_DONE  = done_q;
    assign bus.REQ_RDATA = rdata_q;
    assign bus.REQ_ERR   = err_q;

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB master port among `NUM_REQ` internal requesters (AHB-to-APB bridge, DMA, debug) with round-robin arbitration and an access-timeout watchdog. It sits between the requester-side transaction ports and the APB slave fabric and runs entirely on the APB clock. It generates the APB3/APB4 SETUP/ACCESS sequence and returns read data and error per transfer.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT`, 255: maximum ACCESS cycles waiting for `PREADY`; 0 disables the watchdog. Width 8 bits.
- `PCLK  in  1`: sole clock, rising edge.
- `PRESET  in  1`: reset, asynchronous, active-high.
- `REQ_VALID  in  NUM_REQ`: per-requester transfer request; fields held stable until that requester's `REQ_DONE`.
- `REQ_ADDR  in  32*NUM_REQ`: address, requester i in bits [32i+31:32i].
- `REQ_WRITE  in  NUM_REQ`: 1=write, 0=read.
- `REQ_WDATA  in  32*NUM_REQ`: write data.
- `REQ_STRB  in  4*NUM_REQ`: byte strobes; forced to 0 on reads.
- `REQ_PROT  in  3*NUM_REQ`: protection attributes.
- `REQ_DONE  out  NUM_REQ`: one-cycle completion pulse, one-hot.
- `REQ_RDATA  out  32`: read data, valid with any `REQ_DONE`.
- `REQ_ERR  out  1`: PSLVERR or timeout, valid with any `REQ_DONE`.
- `PSEL PENABLE PWRITE  out  1`; `PADDR PWDATA  out  32`; `PSTRB  out  4`; `PPROT  out  3`: APB master.
- `PRDATA  in  32`; `PREADY PSLVERR  in  1`: APB slave response.

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: if any eligible `REQ_VALID`, pick winner round-robin starting at `last_grant+1` mod NUM_REQ; latch its fields into PADDR/PWRITE/PWDATA/PSTRB/PPROT; set PSEL=1; go to SETUP. `REQ_VALID[i]` is ineligible in the cycle `REQ_DONE[i]` is high.
- SETUP: PENABLE<=1, clear timeout counter, go to ACCESS.
- ACCESS, PREADY=1: PSEL<=0, PENABLE<=0, REQ_DONE[winner]<=1, REQ_RDATA<=PRDATA on a read, or 0 on a write, REQ_ERR<=PSLVERR, last_grant<=winner; go to IDLE.
- ACCESS, PREADY=0: increment the counter. When the counter equals TIMEOUT (TIMEOUT≠0), terminate as above with REQ_ERR=1 and REQ_RDATA=0.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT hold their last value after a transfer. Only PSEL qualifies them.
- Arbitration happens only in IDLE. A request arriving mid-transfer waits, and there is no preemption.
- Reset: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, REQ_DONE=0, REQ_RDATA=0, REQ_ERR=0, last_grant=NUM_REQ-1 (requester 0 has first priority), state=IDLE.
- Reset mid-transfer: the APB outputs drop immediately and asynchronously, and no REQ_DONE is issued. Requesters reissue after reset.

## Timing
- Request seen in IDLE at edge T: PSEL=1 after T, PENABLE=1 after T+1.
- PREADY=1 sampled at the first ACCESS edge T+2: REQ_DONE=1 and PSEL=0 after T+2.
- Minimum transfer is 3 cycles from request to DONE. Each PREADY=0 cycle adds one.
- Back-to-back: the IDLE cycle coincident with DONE can grant another requester. The next PSEL therefore rises one cycle after PSEL falls (1 idle APB cycle).
- Timeout: with TIMEOUT=N, DONE with ERR follows the N-th consecutive PREADY=0 cycle in ACCESS.
- PREADY in SETUP is ignored.
- Simultaneous PREADY=1 and counter=TIMEOUT: the normal completion wins, and REQ_ERR=PSLVERR.

## Structure
- Package `apb_arb_pkg`: FSM state encoding, APB address and data width constants (32/4/3), and the default TIMEOUT.
- Sub-module `apb_rr_pick`: combinational round-robin picker with inputs request vector and last_grant, outputs grant index and `any`. It is instantiated once.
- Top level: FSM, field latch mux, timeout counter.

## Test plan
- Single read, requester 0, PREADY=1 immediately, PRDATA=0xDEADBEEF: PSEL at +1, PENABLE at +2, REQ_DONE[0] at +3, RDATA=0xDEADBEEF, ERR=0.
- Write from requester 1 with ADDR=0x40, WDATA=0x12345678, STRB=0x3, and 2 wait states: PADDR/PWDATA/PSTRB stable through ACCESS; DONE at +5; RDATA=0.
- All requesters hold VALID continuously (NUM_REQ=3): grants go 0,1,2,0,1,2, and every PSEL rise is separated by exactly one PSEL=0 cycle.
- PSLVERR=1 with PREADY on a read: REQ_ERR=1 and REQ_RDATA=PRDATA.
- TIMEOUT=4 with PREADY held low: DONE with ERR=1 and RDATA=0 after the 4th ACCESS wait cycle; PSEL and PENABLE drop; the next request proceeds normally.
- PRESET asserted in ACCESS: PSEL and PENABLE go to 0 without a clock edge; no DONE is issued; after release, requester 0 gets first grant.
